// File: rtl/combo_attack_decoder.sv
`default_nettype none
// ============================================================================
// Module   : combo_attack_decoder
// Brief    : Decodes debounced buttons into attack_state: centre = light attack,
//            U,D,L,R,L,R within a per-step timeout = special attack + cooldown.
//            Define COMBO_MIRROR_EN to swap L/R while the player faces left.
// Revision : 1.0 - initial release
// ============================================================================
module combo_attack_decoder #(
  parameter int TICK_DIV       = 100_000,
  parameter int STEP_TIMEOUT   = 300,
  parameter int HOLD_TICKS     = 50,
  parameter int COOLDOWN_TICKS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_c,
  input  logic       mirrored,
  output logic [1:0] attack_state,
  output logic       special_fire,
  output logic [2:0] combo_progress,
  output logic       cooldown_active
);

  localparam int c_PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_TICK_MAXV = (HOLD_TICKS > COOLDOWN_TICKS) ? HOLD_TICKS : COOLDOWN_TICKS;
  localparam int c_TICK_W    = $clog2(c_TICK_MAXV + 1);
  localparam int c_STEP_W    = $clog2(STEP_TIMEOUT + 1);

  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
  localparam logic [c_TICK_W-1:0]  c_TICK_MAX   = c_TICK_W'(c_TICK_MAXV);
  localparam logic [c_TICK_W-1:0]  c_HOLD_LAST  = c_TICK_W'(HOLD_TICKS - 1);
  localparam logic [c_TICK_W-1:0]  c_COOL_LAST  = c_TICK_W'(COOLDOWN_TICKS - 1);
  localparam logic [c_STEP_W-1:0]  c_STEP_LAST  = c_STEP_W'(STEP_TIMEOUT - 1);
  localparam logic [c_STEP_W-1:0]  c_STEP_MAX   = c_STEP_W'(STEP_TIMEOUT);
  localparam logic [2:0]           c_LAST_STEP  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LIGHT    = 2'd1,
    S_SPECIAL  = 2'd2,
    S_COOLDOWN = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [4:0]           r_btn_q;
  logic [4:0]           w_btn;
  logic [4:0]           w_press;
  logic [3:0]           w_dir;
  logic [3:0]           w_expect;
  logic                 w_multi;
  logic                 w_correct;
  logic                 w_tick;
  logic                 w_step_to;
  logic                 w_matcher_en;
  logic                 w_complete;
  logic                 w_accept;
  logic                 w_state_chg;
  logic [2:0]           r_progress;
  logic [2:0]           w_progress_nxt;
  logic [c_PRESC_W-1:0] r_presc;
  logic [c_TICK_W-1:0]  r_ticks;
  logic [c_STEP_W-1:0]  r_step;
  logic [1:0]           r_attack;
  logic [1:0]           w_attack_nxt;
  logic                 r_fire;
  logic                 w_fire_nxt;
  logic                 r_cool;
  logic                 w_cool_nxt;

  // Bit order: 0=U 1=D 2=L 3=R 4=C
  assign w_btn   = {btn_c, btn_r, btn_l, btn_d, btn_u};
  assign w_press = w_btn & ~r_btn_q;

`ifdef COMBO_MIRROR_EN
  assign w_dir = mirrored ? {w_press[2], w_press[3], w_press[1:0]} : w_press[3:0];
`else
  logic w_unused_mirrored;
  assign w_unused_mirrored = mirrored;
  assign w_dir             = w_press[3:0];
`endif

  always_comb begin
    w_expect = 4'b0000;
    case (r_progress)
      3'd0:       w_expect = 4'b0001;
      3'd1:       w_expect = 4'b0010;
      3'd2, 3'd4: w_expect = 4'b0100;
      3'd3, 3'd5: w_expect = 4'b1000;
      default:    w_expect = 4'b0000;
    endcase
  end

  assign w_multi      = |(w_dir & (w_dir - 4'd1));
  assign w_correct    = (w_expect != 4'd0) && (w_dir == w_expect);
  assign w_tick       = (r_presc == c_PRESC_LAST);
  assign w_step_to    = (r_progress != 3'd0) && w_tick && (r_step == c_STEP_LAST);
  assign w_matcher_en = (r_state == S_IDLE) || (r_state == S_LIGHT);

  always_comb begin
    w_progress_nxt = r_progress;
    w_accept       = 1'b0;
    w_complete     = 1'b0;
    if (!w_matcher_en) begin
      w_progress_nxt = 3'd0;
    end else if (w_dir != 4'd0) begin
      if (w_multi) begin
        w_progress_nxt = 3'd0;
      end else if (w_correct) begin
        w_accept = 1'b1;
        if (r_progress == c_LAST_STEP) begin
          w_complete     = 1'b1;
          w_progress_nxt = 3'd0;
        end else begin
          w_progress_nxt = r_progress + 3'd1;
        end
      end else if (w_dir[0]) begin
        // A stray U is itself the first step of a fresh attempt.
        w_accept       = 1'b1;
        w_progress_nxt = 3'd1;
      end else begin
        w_progress_nxt = 3'd0;
      end
    end else if (w_step_to) begin
      w_progress_nxt = 3'd0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_complete)      w_state_nxt = S_SPECIAL;
        else if (w_press[4]) w_state_nxt = S_LIGHT;
      end
      S_LIGHT: begin
        if (w_complete)                           w_state_nxt = S_SPECIAL;
        else if (w_tick && r_ticks == c_HOLD_LAST) w_state_nxt = S_IDLE;
      end
      S_SPECIAL: begin
        if (w_tick && r_ticks == c_HOLD_LAST) w_state_nxt = S_COOLDOWN;
      end
      S_COOLDOWN: begin
        if (w_tick && r_ticks == c_COOL_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_state_chg  = (w_state_nxt != r_state);
    w_attack_nxt = 2'b00;
    if (w_state_nxt == S_LIGHT)   w_attack_nxt = 2'b01;
    if (w_state_nxt == S_SPECIAL) w_attack_nxt = 2'b11;
    w_fire_nxt = (w_state_nxt == S_SPECIAL) && (r_state != S_SPECIAL);
    w_cool_nxt = (w_state_nxt == S_COOLDOWN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_btn_q    <= 5'd0;
      r_progress <= 3'd0;
      r_presc    <= '0;
      r_ticks    <= '0;
      r_step     <= '0;
      r_attack   <= 2'b00;
      r_fire     <= 1'b0;
      r_cool     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_btn_q    <= w_btn;
      r_progress <= w_progress_nxt;
      r_attack   <= w_attack_nxt;
      r_fire     <= w_fire_nxt;
      r_cool     <= w_cool_nxt;

      // Restarting the divider on entry makes every hold an exact tick multiple.
      if (w_state_chg || w_accept || w_tick) r_presc <= '0;
      else                                   r_presc <= r_presc + c_PRESC_W'(1);

      if (w_state_chg)                            r_ticks <= '0;
      else if (w_tick && r_ticks != c_TICK_MAX)   r_ticks <= r_ticks + c_TICK_W'(1);

      if (w_progress_nxt == 3'd0 || w_accept)     r_step <= '0;
      else if (w_tick && r_step != c_STEP_MAX)    r_step <= r_step + c_STEP_W'(1);
    end
  end

  assign attack_state    = r_attack;
  assign special_fire    = r_fire;
  assign combo_progress  = r_progress;
  assign cooldown_active = r_cool;

endmodule
`default_nettype wire

// File: tb/tb_combo_attack_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_combo_attack_decoder
// Brief    : Randomised + directed bench for combo_attack_decoder with a
//            queue-based scoreboard fed by a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_combo_attack_decoder;

  localparam int TD = 4;
  localparam int ST = 10;
  localparam int HT = 3;
  localparam int CT = 5;

`ifdef COMBO_MIRROR_EN
  localparam bit MIRROR_EN = 1'b1;
`else
  localparam bit MIRROR_EN = 1'b0;
`endif

  localparam logic [4:0] B_U = 5'b00001;
  localparam logic [4:0] B_D = 5'b00010;
  localparam logic [4:0] B_L = 5'b00100;
  localparam logic [4:0] B_R = 5'b01000;
  localparam logic [4:0] B_C = 5'b10000;

  localparam int MD_IDLE = 0;
  localparam int MD_LIGHT = 1;
  localparam int MD_SPECIAL = 2;
  localparam int MD_COOL = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_c = 1'b0;
  logic       mirrored = 1'b0;
  logic [1:0] attack_state;
  logic       special_fire;
  logic [2:0] combo_progress;
  logic       cooldown_active;

  always #5 clk = ~clk;

  combo_attack_decoder #(
    .TICK_DIV(TD), .STEP_TIMEOUT(ST), .HOLD_TICKS(HT), .COOLDOWN_TICKS(CT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r), .btn_c(btn_c),
    .mirrored(mirrored),
    .attack_state(attack_state), .special_fire(special_fire),
    .combo_progress(combo_progress), .cooldown_active(cooldown_active)
  );

  typedef struct packed {
    logic [1:0] atk;
    logic       fire;
    logic [2:0] prog;
    logic       cool;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: mode, matched steps, cycles since divider restart, ticks.
  int         m_mode = MD_IDLE;
  int         m_prog = 0;
  int         m_phase = 0;
  int         m_sticks = 0;
  int         m_step = 0;
  logic [4:0] m_prev = 5'd0;
  int         seq_bit[6] = '{0, 1, 2, 3, 2, 3};

  logic cur_mir = 1'b0;

  // Observed activity, updated by the monitor.
  int obs_fire = 0, obs_light_cyc = 0;
  int run_light = 0, run_spec = 0, run_cool = 0;
  int last_light = 0, last_spec = 0, last_cool = 0;

  task automatic model_step(input logic [4:0] btn, input logic mir, input logic rstn);
    logic [4:0] pr;
    logic [3:0] dirs;
    bit         tick, acc, done;
    int         n, np, nm;
    exp_t       e;
    pr     = btn & ~m_prev;
    m_prev = rstn ? btn : 5'd0;
    if (!rstn) begin
      m_mode = MD_IDLE; m_prog = 0; m_phase = 0; m_sticks = 0; m_step = 0;
      e = '0;
      exp_q.push_back(e);
      return;
    end
    dirs = pr[3:0];
    if (MIRROR_EN && mir) dirs = {pr[2], pr[3], pr[1:0]};
    n    = $countones(dirs);
    tick = (m_phase % TD) == TD - 1;
    acc  = 0;
    done = 0;
    np   = m_prog;
    if (m_mode == MD_SPECIAL || m_mode == MD_COOL) np = 0;
    else if (n >= 2) np = 0;
    else if (n == 1) begin
      if (dirs[seq_bit[m_prog]]) begin
        acc = 1;
        if (m_prog == 5) begin done = 1; np = 0; end
        else np = m_prog + 1;
      end else if (dirs[0]) begin
        acc = 1; np = 1;
      end else np = 0;
    end else if (m_prog > 0 && tick && m_step + 1 >= ST) np = 0;

    if (np == 0 || acc) m_step = 0;
    else if (tick) m_step++;

    nm = m_mode;
    case (m_mode)
      MD_IDLE:    if (done) nm = MD_SPECIAL; else if (pr[4]) nm = MD_LIGHT;
      MD_LIGHT:   if (done) nm = MD_SPECIAL; else if (tick && m_sticks + 1 == HT) nm = MD_IDLE;
      MD_SPECIAL: if (tick && m_sticks + 1 == HT) nm = MD_COOL;
      default:    if (tick && m_sticks + 1 == CT) nm = MD_IDLE;
    endcase

    if (nm != m_mode) m_sticks = 0;
    else if (tick && m_sticks < CT) m_sticks++;
    if (nm != m_mode || acc) m_phase = 0;
    else m_phase++;

    e.atk  = (nm == MD_LIGHT) ? 2'b01 : (nm == MD_SPECIAL) ? 2'b11 : 2'b00;
    e.fire = (nm == MD_SPECIAL) && (m_mode != MD_SPECIAL);
    e.prog = 3'(np);
    e.cool = (nm == MD_COOL);
    m_mode = nm;
    m_prog = np;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [4:0] btn, input logic mir, input logic rstn);
    @(negedge clk);
    {btn_c, btn_r, btn_l, btn_d, btn_u} = btn;
    mirrored = mir;
    rst_n    = rstn;
    model_step(btn, mir, rstn);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(5'd0, cur_mir, 1'b1);
  endtask

  task automatic tap(input logic [4:0] b, input int hold, input int gap);
    repeat (hold) cyc(b, cur_mir, 1'b1);
    idle(gap);
  endtask

  task automatic combo(input bit swap);
    tap(B_U, 2, 4);
    tap(B_D, 2, 4);
    tap(swap ? B_R : B_L, 2, 4);
    tap(swap ? B_L : B_R, 2, 4);
    tap(swap ? B_R : B_L, 2, 4);
    tap(swap ? B_L : B_R, 2, 4);
  endtask

  task automatic check_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: one expected entry per clock, compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({attack_state, special_fire, combo_progress, cooldown_active} !== e) begin
          failures++;
          $display("FAIL outputs t=%0t: got atk=%b fire=%b prog=%0d cool=%b, expected atk=%b fire=%b prog=%0d cool=%b",
                   $time, attack_state, special_fire, combo_progress, cooldown_active,
                   e.atk, e.fire, e.prog, e.cool);
        end
      end
      if (special_fire === 1'b1) obs_fire++;
      if (attack_state === 2'b01) begin run_light++; obs_light_cyc++; end
      else if (run_light > 0) begin last_light = run_light; run_light = 0; end
      if (attack_state === 2'b11) run_spec++;
      else if (run_spec > 0) begin last_spec = run_spec; run_spec = 0; end
      if (cooldown_active === 1'b1) run_cool++;
      else if (run_cool > 0) begin last_cool = run_cool; run_cool = 0; end
    end
  end

  initial begin
    int f0, l0;
    logic [4:0] b;

    cyc(5'd0, 1'b0, 1'b0);
    cyc(B_C, 1'b0, 1'b0);
    cyc(B_C, 1'b0, 1'b1);
    idle(16);
    check_eq("light_after_reset_held_c", last_light, 12);

    f0 = obs_fire;
    tap(B_C, 1, 20);
    check_eq("light_len", last_light, 12);
    check_eq("light_no_fire", obs_fire - f0, 0);

    f0 = obs_fire;
    combo(1'b0);
    idle(40);
    check_eq("combo_fire_count", obs_fire - f0, 1);
    check_eq("special_len", last_spec, 12);
    check_eq("cooldown_len", last_cool, 20);

    f0 = obs_fire;
    tap(B_U, 2, 4); tap(B_D, 2, 4); tap(B_L, 2, 4);
    idle(41);
    check_eq("timeout_progress", combo_progress, 0);
    tap(B_R, 2, 4); tap(B_L, 2, 4); tap(B_R, 2, 4);
    idle(20);
    check_eq("timeout_no_special", obs_fire - f0, 0);

    tap(B_U, 2, 4); tap(B_D, 2, 4); tap(B_U, 2, 4);
    check_eq("udu_progress", combo_progress, 1);
    idle(45);
    f0 = obs_fire;
    tap(B_U, 2, 4); tap(B_D, 2, 4); tap(B_L, 2, 4); tap(B_R, 2, 4); tap(B_L, 2, 4);
    tap(B_R | B_L, 2, 4);
    check_eq("multi_press_progress", combo_progress, 0);
    idle(10);
    check_eq("multi_press_no_special", obs_fire - f0, 0);

    combo(1'b0);
    idle(10);
    l0 = obs_light_cyc;
    tap(B_C, 1, 30);
    check_eq("cooldown_ignores_c", obs_light_cyc - l0, 0);
    check_eq("cooldown_len_2", last_cool, 20);

    combo(1'b0);
    cyc(5'd0, cur_mir, 1'b0);
    @(posedge clk);
    #2;
    check_eq("reset_in_special", {attack_state, special_fire, combo_progress, cooldown_active}, 0);
    idle(10);

    f0 = obs_fire;
    cur_mir = 1'b1;
    combo(1'b1);
    idle(40);
    check_eq("mirrored_swapped_combo", obs_fire - f0, MIRROR_EN ? 1 : 0);
    f0 = obs_fire;
    cur_mir = 1'b0;
    combo(1'b1);
    idle(40);
    check_eq("unmirrored_swapped_combo", obs_fire - f0, 0);

    for (int it = 0; it < 200; it++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 60) begin
        for (int s = 0; s < 6; s++) begin
          b = 5'd1 << seq_bit[s];
          if ($urandom_range(0, 99) < 15) b = 5'($urandom_range(1, 15));
          if ($urandom_range(0, 99) < 10) b = b | B_C;
          cur_mir = 1'($urandom_range(0, 1));
          tap(b, $urandom_range(1, 3),
              ($urandom_range(0, 99) < 8) ? $urandom_range(35, 50) : $urandom_range(0, 12));
        end
      end else if (sel < 80) begin
        for (int k = 0; k < 20; k++) begin
          b = 5'd0;
          for (int j = 0; j < 5; j++) if ($urandom_range(0, 99) < 15) b[j] = 1'b1;
          cyc(b, 1'($urandom_range(0, 1)), 1'b1);
        end
      end else if (sel < 85) begin
        cyc(5'($urandom_range(0, 31)), cur_mir, 1'b0);
      end else begin
        idle($urandom_range(0, 60));
      end
    end

    idle(2);
    @(posedge clk);
    #2;
    check_eq("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
